// File: rtl/dram_ctrl_pkg.sv
// Shared types and sizing helpers for the DRAM controller PHY-side blocks.
package dram_ctrl_pkg;

    localparam int CMD_WIDTH        = 3;
    localparam int RW_CONTROL_WIDTH = 3;

    // Scheduler-to-PHY command codes; the two spare encodings decode as NOP.
    typedef enum logic [CMD_WIDTH-1:0] {
        NOP = 3'd0,
        ACT = 3'd1,
        RD  = 3'd2,
        WR  = 3'd3,
        PRE = 3'd4,
        REF = 3'd5
    } cmd_e;

    // Read/write datapath phase, exported on rw_control_state.
    typedef enum logic [RW_CONTROL_WIDTH-1:0] {
        RW_IDLE  = 3'd0,
        WR_WAIT  = 3'd1,
        WR_BURST = 3'd2,
        RD_WAIT  = 3'd3,
        RD_BURST = 3'd4
    } rw_state_e;

    // Beats per scheduler word.
    function automatic int calc_burst(input int data_width, input int dq_width);
        return data_width / dq_width;
    endfunction

    // Beat index width; one spare bit so BURST itself is representable.
    function automatic int calc_io_cnt_width(input int burst);
        return $clog2(burst) + 1;
    endfunction

    localparam int IO_CNT_WIDTH = calc_io_cnt_width(calc_burst(128, 16));

endpackage

// File: rtl/phy_cmd_encoder.sv
// Combinational decode of a scheduler command into DRAM {cs_n, ras_n, cas_n, we_n}.
module phy_cmd_encoder
    import dram_ctrl_pkg::*;
(
    input  logic [CMD_WIDTH-1:0] command,
    output logic [3:0]           pins
);

    // Truth table of the DRAM command pins; anything unrecognised is a deselect/NOP.
    always_comb begin
        pins = 4'b1111;
        case (command)
            ACT:     pins = 4'b0011;
            RD:      pins = 4'b0101;
            WR:      pins = 4'b0100;
            PRE:     pins = 4'b0010;
            REF:     pins = 4'b0001;
            default: pins = 4'b1111;
        endcase
    end

endmodule

// File: rtl/phy_cmd_data_ctrl.sv
// PHY-side endpoint between the bank scheduler and the DRAM pads: registered
// command/address pins, write-data serialiser and read-data gatherer.
module phy_cmd_data_ctrl
    import dram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 128,
    parameter int DQ_WIDTH       = 16,
    parameter int ROW_ADDR_WIDTH = 16,
    parameter int COL_ADDR_WIDTH = 10,
    parameter int T_CWL          = 4,
    parameter int T_CL           = 5
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [CMD_WIDTH-1:0]          command,
    input  logic [ROW_ADDR_WIDTH-1:0]     row_addr,
    input  logic [COL_ADDR_WIDTH-1:0]     col_addr,
    input  logic [DATA_WIDTH-1:0]         data_wr_phy,
    output logic [DATA_WIDTH-1:0]         data_read_phy,
    output logic                          rd_data_valid,
    output logic                          data_full_write_phy,
    output logic [RW_CONTROL_WIDTH-1:0]   rw_control_state,
    output logic [calc_io_cnt_width(calc_burst(DATA_WIDTH, DQ_WIDTH))-1:0] read_write_io_cnt,
    output logic                          dram_cs_n,
    output logic                          dram_ras_n,
    output logic                          dram_cas_n,
    output logic                          dram_we_n,
    output logic [ROW_ADDR_WIDTH-1:0]     dram_addr,
    output logic [DQ_WIDTH-1:0]           dq_out,
    output logic                          dq_oe,
    input  logic [DQ_WIDTH-1:0]           dq_in
);

    localparam int BURST  = calc_burst(DATA_WIDTH, DQ_WIDTH);
    localparam int IO_W   = calc_io_cnt_width(BURST);
    localparam int T_MAX  = (T_CWL > T_CL) ? T_CWL : T_CL;
    localparam int WAIT_W = $clog2(T_MAX) + 1;

    localparam logic [RW_CONTROL_WIDTH-1:0] S_IDLE     = RW_IDLE;
    localparam logic [RW_CONTROL_WIDTH-1:0] S_WR_WAIT  = WR_WAIT;
    localparam logic [RW_CONTROL_WIDTH-1:0] S_WR_BURST = WR_BURST;
    localparam logic [RW_CONTROL_WIDTH-1:0] S_RD_WAIT  = RD_WAIT;
    localparam logic [RW_CONTROL_WIDTH-1:0] S_RD_BURST = RD_BURST;

    logic [RW_CONTROL_WIDTH-1:0] state_reg, state_next;
    logic [WAIT_W-1:0]           wait_cnt_reg;
    logic [IO_W-1:0]             io_cnt_reg;
    logic [DATA_WIDTH-1:0]       wr_shift_reg;
    logic [DATA_WIDTH-1:0]       rd_asm_reg;
    logic [DATA_WIDTH-1:0]       rd_assembled;
    logic [ROW_ADDR_WIDTH-1:0]   addr_next;
    logic [3:0]                  enc_pins;
    logic                        accept;
    logic                        accept_wr;
    logic                        accept_rd;
    logic                        wait_zero;
    logic                        last_beat;
    logic                        wr_beat_load;

    assign cmd_ready         = (state_reg == S_IDLE);
    assign accept            = cmd_valid && cmd_ready;
    assign accept_wr         = accept && (command == WR);
    assign accept_rd         = accept && (command == RD);
    assign wait_zero         = (wait_cnt_reg == '0);
    assign last_beat         = (io_cnt_reg == IO_W'(BURST - 1));
    assign rw_control_state  = state_reg;
    assign read_write_io_cnt = io_cnt_reg;

    // A new write beat goes onto DQ on leaving the CWL wait and on every non-final burst cycle.
    assign wr_beat_load = ((state_reg == S_WR_WAIT) && wait_zero) ||
                          ((state_reg == S_WR_BURST) && !last_beat);

    phy_cmd_encoder u_encoder (
        .command (command),
        .pins    (enc_pins)
    );

    // The read word with the beat currently on DQ merged into its slice.
    genvar gi;
    generate
        for (gi = 0; gi < BURST; gi++) begin : g_rd_slice
            assign rd_assembled[gi*DQ_WIDTH +: DQ_WIDTH] =
                (io_cnt_reg == IO_W'(gi)) ? dq_in : rd_asm_reg[gi*DQ_WIDTH +: DQ_WIDTH];
        end
    endgenerate

    // Address presented with the command: row for ACT, zero-extended column for RD/WR.
    always_comb begin
        addr_next = '0;
        if (accept) begin
            case (command)
                ACT:     addr_next = row_addr;
                RD, WR:  addr_next = ROW_ADDR_WIDTH'(col_addr);
                default: addr_next = '0;
            endcase
        end
    end

    // Next-state logic; only RD and WR leave idle, everything else completes in one cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept_wr)      state_next = S_WR_WAIT;
                else if (accept_rd) state_next = S_RD_WAIT;
            end
            S_WR_WAIT:  if (wait_zero) state_next = S_WR_BURST;
            S_WR_BURST: if (last_beat) state_next = S_IDLE;
            S_RD_WAIT:  if (wait_zero) state_next = S_RD_BURST;
            S_RD_BURST: if (last_beat) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    // Command pins and address are registered: they show the accepted command for exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} <= 4'b1111;
            dram_addr <= '0;
        end else begin
            {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} <= accept ? enc_pins : 4'b1111;
            dram_addr <= addr_next;
        end
    end

    // CWL/CL wait counter; loaded so the burst starts the cycle after it reaches zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
        end else if (accept_wr) begin
            wait_cnt_reg <= WAIT_W'(T_CWL - 1);
        end else if (accept_rd) begin
            wait_cnt_reg <= WAIT_W'(T_CL - 1);
        end else if (((state_reg == S_WR_WAIT) || (state_reg == S_RD_WAIT)) && !wait_zero) begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
        end
    end

    // Beat index: counts through either burst, held at zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_cnt_reg <= '0;
        end else if ((state_reg == S_WR_BURST) || (state_reg == S_RD_BURST)) begin
            io_cnt_reg <= last_beat ? '0 : io_cnt_reg + 1'b1;
        end else begin
            io_cnt_reg <= '0;
        end
    end

    // Write serialiser: shift the captured word out LSB-first, flag the final beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_shift_reg        <= '0;
            dq_out              <= '0;
            dq_oe               <= 1'b0;
            data_full_write_phy <= 1'b0;
        end else begin
            data_full_write_phy <= 1'b0;
            if (accept_wr) begin
                wr_shift_reg <= data_wr_phy;
            end
            if (wr_beat_load) begin
                dq_out              <= wr_shift_reg[DQ_WIDTH-1:0];
                wr_shift_reg        <= wr_shift_reg >> DQ_WIDTH;
                dq_oe               <= 1'b1;
                data_full_write_phy <= (state_reg == S_WR_BURST) &&
                                       (io_cnt_reg == IO_W'(BURST - 2));
            end else if (state_reg == S_WR_BURST) begin
                dq_out <= '0;
                dq_oe  <= 1'b0;
            end
        end
    end

    // Read gatherer: collect beats into their slices, publish the full word after the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_asm_reg    <= '0;
            data_read_phy <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            rd_data_valid <= 1'b0;
            if (state_reg == S_RD_BURST) begin
                rd_asm_reg <= rd_assembled;
                if (last_beat) begin
                    data_read_phy <= rd_assembled;
                    rd_data_valid <= 1'b1;
                end
            end
        end
    end

endmodule
